// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a circular return-address stack.
// Selects the next PC from sequential, branch, jump or jump-register sources,
// predicts returns through the RAS, and flags return mispredicts and
// misaligned register targets one cycle after the offending instruction.

module pc_sequencer #(
    parameter int               WIDTH     = 32,
    parameter int               ADR_W     = 26,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [1:0]       sel,
    input  logic             link,
    input  logic             ret,
    input  logic [ADR_W-1:0] jump_adr,
    input  logic [WIDTH-1:0] branch_off,
    input  logic [WIDTH-1:0] reg_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             mispredict,
    output logic             misalign
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] SEL_SEQ    = 2'd0;
    localparam logic [1:0] SEL_BRANCH = 2'd1;
    localparam logic [1:0] SEL_JUMP   = 2'd2;
    localparam logic [1:0] SEL_JREG   = 2'd3;

    // Return-address stack storage; top_ptr indexes the most recent entry.
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] ras_count;

    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] jreg_target;
    logic [WIDTH-1:0] next_pc;

    logic             do_link;
    logic             do_ret;
    logic             pop_valid;

    logic             ras_wr_en;
    logic [PTR_W-1:0] ras_wr_idx;
    logic [PTR_W-1:0] ptr_next;
    logic [CNT_W-1:0] count_next;

    logic             mispredict_next;
    logic             misalign_next;

    // Target arithmetic; all sums wrap modulo 2^WIDTH.
    assign pc_plus4      = pc + WIDTH'(4);
    assign branch_target = pc_plus4 + {branch_off[WIDTH-3:0], 2'b00};
    assign jreg_target   = {reg_target[WIDTH-1:2], 2'b00};

    // The jump keeps the upper PC bits only when the field does not fill the PC.
    generate
        if (WIDTH > ADR_W + 2) begin : g_jump_region
            assign jump_target = {pc_plus4[WIDTH-1:ADR_W+2], jump_adr, 2'b00};
        end else begin : g_jump_full
            assign jump_target = {jump_adr, 2'b00};
        end
    endgenerate

    // Stack occupancy and the visible top entry (zero when nothing is stored).
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
    assign ras_top   = ras_empty ? '0 : ras_mem[top_ptr];

    // Link and return only have meaning on jump / jump-register instructions.
    assign do_link   = link && ((sel == SEL_JUMP) || (sel == SEL_JREG));
    assign do_ret    = ret && (sel == SEL_JREG);
    assign pop_valid = do_ret && !ras_empty;

    // Next-PC multiplexer.
    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            SEL_SEQ:    next_pc = pc_plus4;
            SEL_BRANCH: next_pc = branch_target;
            SEL_JUMP:   next_pc = jump_target;
            SEL_JREG:   next_pc = jreg_target;
            default:    next_pc = pc_plus4;
        endcase
    end

    // Stack pointer/count update: replace-top, push (overwriting oldest when full) or pop.
    always_comb begin
        ras_wr_en  = 1'b0;
        ras_wr_idx = top_ptr;
        ptr_next   = top_ptr;
        count_next = ras_count;
        if (do_link && do_ret && !ras_empty) begin
            ras_wr_en  = 1'b1;
            ras_wr_idx = top_ptr;
        end else if (do_link) begin
            ras_wr_en  = 1'b1;
            ras_wr_idx = top_ptr + PTR_W'(1);
            ptr_next   = top_ptr + PTR_W'(1);
            if (!ras_full) begin
                count_next = ras_count + CNT_W'(1);
            end
        end else if (pop_valid) begin
            ptr_next   = top_ptr - PTR_W'(1);
            count_next = ras_count - CNT_W'(1);
        end
    end

    // Status flags computed from the instruction being accepted this cycle.
    always_comb begin
        mispredict_next = 1'b0;
        misalign_next   = 1'b0;
        if (!stall) begin
            mispredict_next = pop_valid && (ras_top != jreg_target);
            misalign_next   = (sel == SEL_JREG) && (reg_target[1:0] != 2'b00);
        end
    end

    // PC register; holds on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (!stall) begin
            pc <= next_pc;
        end
    end

    // Stack pointer and occupancy count; hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_ptr   <= '0;
            ras_count <= '0;
        end else if (!stall) begin
            top_ptr   <= ptr_next;
            ras_count <= count_next;
        end
    end

    // Stack entries; cleared on reset, written by push or replace-top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else if (!stall && ras_wr_en) begin
            ras_mem[ras_wr_idx] <= pc_plus4;
        end
    end

    // One-cycle mispredict and misalign pulses; a stall cycle clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            mispredict <= mispredict_next;
            misalign   <= misalign_next;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer.
// Stimulus pushes hand-computed expectations into a queue; a monitor process
// pops and compares after each clock edge or asynchronous reset.

module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [1:0]  sel;
    logic        link;
    logic        ret;
    logic [25:0] jump_adr;
    logic [31:0] branch_off;
    logic [31:0] reg_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_full;
    logic        mispredict;
    logic        misalign;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] top;
        logic        empty;
        logic        full;
        logic        mis;
        logic        mal;
    } exp_t;

    exp_t exp_q [$];

    pc_sequencer #(
        .WIDTH     (32),
        .ADR_W     (26),
        .RAS_DEPTH (4),
        .RESET_PC  (32'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .sel        (sel),
        .link       (link),
        .ret        (ret),
        .jump_adr   (jump_adr),
        .branch_off (branch_off),
        .reg_target (reg_target),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .ras_top    (ras_top),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full),
        .mispredict (mispredict),
        .misalign   (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk(input string n, input logic [31:0] p, input logic [31:0] t,
                                input logic e, input logic f, input logic m, input logic a);
        exp_t r;
        r.name  = n;
        r.pc    = p;
        r.top   = t;
        r.empty = e;
        r.full  = f;
        r.mis   = m;
        r.mal   = a;
        return r;
    endfunction

    task automatic check32(input string n, input string field, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s.%s actual=0x%08h required=0x%08h", n, field, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        check32(e.name, "pc",         pc,                 e.pc);
        check32(e.name, "ras_top",    ras_top,            e.top);
        check32(e.name, "ras_empty",  {31'b0, ras_empty}, {31'b0, e.empty});
        check32(e.name, "ras_full",   {31'b0, ras_full},  {31'b0, e.full});
        check32(e.name, "mispredict", {31'b0, mispredict}, {31'b0, e.mis});
        check32(e.name, "misalign",   {31'b0, misalign},  {31'b0, e.mal});
    endtask

    task automatic applyStimulus(input logic st, input logic [1:0] s, input logic lk, input logic rt,
                                 input logic [25:0] ja, input logic [31:0] bo, input logic [31:0] rg,
                                 input exp_t e);
        @(negedge clk);
        stall      = st;
        sel        = s;
        link       = lk;
        ret        = rt;
        jump_adr   = ja;
        branch_off = bo;
        reg_target = rg;
        exp_q.push_back(e);
    endtask

    // Reset asserted between clock edges with a push pending on the inputs.
    task automatic doReset(input string n);
        @(negedge clk);
        stall = 1'b0;
        sel   = 2'd2;
        link  = 1'b1;
        ret   = 1'b0;
        jump_adr = 26'h10;
        #2;
        exp_q.push_back(mk(n, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        stall = 1'b1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare the oldest expectation after each edge that updates outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        mismatched++;
        $display("[TB] FAIL watchdog timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        rst_n      = 1'b1;
        stall      = 1'b1;
        sel        = 2'd0;
        link       = 1'b0;
        ret        = 1'b0;
        jump_adr   = '0;
        branch_off = '0;
        reg_target = '0;
        #3;
        exp_q.push_back(mk("reset", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch
        applyStimulus(0, 2'd0, 0, 0, 26'h0, 32'h0, 32'h0, mk("seq1", 32'h4, 0, 1, 0, 0, 0));
        applyStimulus(0, 2'd0, 0, 0, 26'h0, 32'h0, 32'h0, mk("seq2", 32'h8, 0, 1, 0, 0, 0));
        applyStimulus(0, 2'd0, 0, 0, 26'h0, 32'h0, 32'h0, mk("seq3", 32'hC, 0, 1, 0, 0, 0));

        // Jump keeps upper PC region bits
        applyStimulus(0, 2'd3, 0, 0, 26'h0, 32'h0, 32'h40000010, mk("jr_setup", 32'h40000010, 0, 1, 0, 0, 0));
        applyStimulus(0, 2'd2, 0, 0, 26'h100, 32'h0, 32'h0, mk("jump", 32'h40000400, 0, 1, 0, 0, 0));

        // Negative branch
        applyStimulus(0, 2'd3, 0, 0, 26'h0, 32'h0, 32'h100, mk("jr_100", 32'h100, 0, 1, 0, 0, 0));
        applyStimulus(0, 2'd1, 0, 0, 26'h0, 32'hFFFFFFFE, 32'h0, mk("branch_neg", 32'hFC, 0, 1, 0, 0, 0));

        // Sequential wrap-around
        applyStimulus(0, 2'd3, 0, 0, 26'h0, 32'h0, 32'hFFFFFFFC, mk("jr_top", 32'hFFFFFFFC, 0, 1, 0, 0, 0));
        applyStimulus(0, 2'd0, 0, 0, 26'h0, 32'h0, 32'h0, mk("wrap", 32'h0, 0, 1, 0, 0, 0));

        // Five jal pushes into a 4-deep stack
        applyStimulus(0, 2'd2, 1, 0, 26'h10, 32'h0, 32'h0, mk("jal1", 32'h40,  32'h4,   0, 0, 0, 0));
        applyStimulus(0, 2'd2, 1, 0, 26'h20, 32'h0, 32'h0, mk("jal2", 32'h80,  32'h44,  0, 0, 0, 0));
        applyStimulus(0, 2'd2, 1, 0, 26'h30, 32'h0, 32'h0, mk("jal3", 32'hC0,  32'h84,  0, 0, 0, 0));
        applyStimulus(0, 2'd2, 1, 0, 26'h40, 32'h0, 32'h0, mk("jal4", 32'h100, 32'hC4,  0, 1, 0, 0));
        applyStimulus(0, 2'd2, 1, 0, 26'h50, 32'h0, 32'h0, mk("jal5", 32'h140, 32'h104, 0, 1, 0, 0));

        // Four matching returns; the oldest entry (0x4) was overwritten
        applyStimulus(0, 2'd3, 0, 1, 26'h0, 32'h0, 32'h104, mk("ret1", 32'h104, 32'hC4, 0, 0, 0, 0));
        applyStimulus(0, 2'd3, 0, 1, 26'h0, 32'h0, 32'hC4,  mk("ret2", 32'hC4,  32'h84, 0, 0, 0, 0));
        applyStimulus(0, 2'd3, 0, 1, 26'h0, 32'h0, 32'h84,  mk("ret3", 32'h84,  32'h44, 0, 0, 0, 0));
        applyStimulus(0, 2'd3, 0, 1, 26'h0, 32'h0, 32'h44,  mk("ret4", 32'h44,  32'h0,  1, 0, 0, 0));

        // Pop from empty stack, and link/ret on sequential/branch are ignored
        applyStimulus(0, 2'd3, 0, 1, 26'h0, 32'h0, 32'h300, mk("pop_empty", 32'h300, 0, 1, 0, 0, 0));
        applyStimulus(0, 2'd0, 1, 1, 26'h0, 32'h0, 32'h0,   mk("seq_link",  32'h304, 0, 1, 0, 0, 0));
        applyStimulus(0, 2'd1, 1, 1, 26'h0, 32'h0, 32'h0,   mk("br_link",   32'h308, 0, 1, 0, 0, 0));

        // Mispredicted return, then misaligned register jump
        applyStimulus(0, 2'd3, 0, 0, 26'h0,  32'h0, 32'h1FC, mk("jr_1fc",  32'h1FC, 0,      1, 0, 0, 0));
        applyStimulus(0, 2'd2, 1, 0, 26'h80, 32'h0, 32'h0,   mk("jal_200", 32'h200, 32'h200, 0, 0, 0, 0));
        applyStimulus(0, 2'd3, 0, 1, 26'h0,  32'h0, 32'h204, mk("ret_mis", 32'h204, 0,      1, 0, 1, 0));
        applyStimulus(0, 2'd3, 0, 0, 26'h0,  32'h0, 32'h203, mk("misalign", 32'h200, 0,     1, 0, 0, 1));
        applyStimulus(0, 2'd0, 0, 0, 26'h0,  32'h0, 32'h0,   mk("flags_clear", 32'h204, 0,  1, 0, 0, 0));

        // Simultaneous pop and push replaces the top entry
        applyStimulus(0, 2'd2, 1, 0, 26'h100, 32'h0, 32'h0,   mk("jal_400", 32'h400, 32'h208, 0, 0, 0, 0));
        applyStimulus(0, 2'd3, 1, 1, 26'h0,   32'h0, 32'h500, mk("poppush", 32'h500, 32'h404, 0, 0, 1, 0));

        // Stall holds pc and stack, clears the mispredict pulse
        applyStimulus(1, 2'd2, 1, 0, 26'h10, 32'h0, 32'h0, mk("stall1", 32'h500, 32'h404, 0, 0, 0, 0));
        applyStimulus(1, 2'd2, 1, 0, 26'h10, 32'h0, 32'h0, mk("stall2", 32'h500, 32'h404, 0, 0, 0, 0));
        applyStimulus(1, 2'd2, 1, 0, 26'h10, 32'h0, 32'h0, mk("stall3", 32'h500, 32'h404, 0, 0, 0, 0));

        // Pop back to empty, then pop+push on an empty stack yields one entry
        applyStimulus(0, 2'd3, 0, 1, 26'h0, 32'h0, 32'h404, mk("ret_404",     32'h404, 0,      1, 0, 0, 0));
        applyStimulus(0, 2'd3, 1, 1, 26'h0, 32'h0, 32'h600, mk("poppush_emp", 32'h600, 32'h408, 0, 0, 0, 0));

        // Asynchronous reset mid-stream discards the pending push
        doReset("reset_mid");
        applyStimulus(0, 2'd0, 0, 0, 26'h0, 32'h0, 32'h0, mk("post_reset", 32'h4, 0, 1, 0, 0, 0));

        repeat (3) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
